// File: rtl/handshake_fifo.sv
// Synchronous valid/ready FIFO with occupancy count and almost-full flag.
// Storage is a small register array; pointers wrap modulo DEPTH (power of two).
module handshake_fifo #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DWIDTH-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DWIDTH-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              almost_full_q, almost_full_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              push_c;
  logic              pop_c;

  // Accept whenever not full; independent of out_ready so a full FIFO never passes through.
  assign in_ready = (count_q != CW'(DEPTH)) && !rst;

  // Next-state for pointers, occupancy and the state-derived flags.
  always_comb begin
    push_c        = in_valid && in_ready;
    pop_c         = out_valid_q && out_ready && !rst;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    out_valid_d   = (count_d != '0);
    almost_full_d = (count_d >= CW'(AFULL_TH));
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      almost_full_q <= (AFULL_TH == 0);
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage array; not reset, contents are only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule

// File: doc/handshake_fifo.md
HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8: width of the data payload in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of storage entries; legal values are powers of two, minimum 2.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-1: occupancy at or above which almost_full asserts; legal range is 1..DEPTH.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_data  input  DWIDTH  upstream payload.
REQ-008 in_ready  output  1  FIFO can accept a word this cycle.
REQ-009 out_valid  output  1  out_data holds the oldest stored word.
REQ-010 out_data  output  DWIDTH  head-of-queue payload.
REQ-011 out_ready  input  1  downstream (e.g. arbiter input) accepts out_data.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 almost_full  output  1  count >= AFULL_TH.

Function
REQ-014 A push SHALL occur exactly in a cycle where in_valid && in_ready; a pop SHALL occur exactly in a cycle where out_valid && out_ready.
REQ-015 in_ready SHALL equal (count != DEPTH) && !rst, combinationally; it SHALL NOT depend on in_valid or out_ready, so there is no full-FIFO pass-through on a same-cycle pop.
REQ-016 out_valid SHALL equal (count != 0), derived from registered state only, with no combinational path from in_valid.
REQ-017 A word pushed into an empty FIFO SHALL appear on out_data with out_valid=1 in the cycle after the push (latency 1).
REQ-018 Words SHALL leave in strict push order; no word is dropped, duplicated or reordered.
REQ-019 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Write and read pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-021 count SHALL change on the next edge as follows:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged
  - neither: count unchanged
REQ-022 Simultaneous push and pop SHALL be legal at any occupancy from 1 to DEPTH-1; at count=DEPTH only a pop can occur, and at count=0 only a push can occur.
REQ-023 count SHALL never exceed DEPTH nor underflow below 0; in_valid asserted while in_ready=0 SHALL have no effect on any state.
REQ-024 out_data SHALL be don't-care while out_valid=0; a bench SHALL NOT check it then.
REQ-025 almost_full SHALL be registered-state-derived and update in the same cycle as count.

Reset
REQ-026 While rst=1 at a rising edge, the write pointer, read pointer and count SHALL be cleared to 0; the storage array is not reset.
REQ-027 During and after reset, outputs SHALL read as follows until the first push:
  - in_ready: 0 while rst=1, 1 in the first cycle after rst deasserts
  - out_valid: 0
  - count: 0
  - almost_full: 0, or 1 if AFULL_TH=0 is ever configured (illegal)
REQ-028 Reset asserted mid-operation SHALL discard all stored words, and no pre-reset word SHALL ever appear at the output afterwards.
REQ-029 A push or pop presented in a cycle with rst=1 SHALL be ignored.

Verification (DEPTH=4, DWIDTH=8, AFULL_TH=3)
REQ-030 Single word: push 0xA5 into the empty FIFO -> next cycle out_valid=1, out_data=0xA5, count=1; pop it -> count=0, out_valid=0.
REQ-031 Fill with out_ready=0: push 0x01..0x04 -> after the 3rd push almost_full=1; after the 4th push count=4 and in_ready=0; 0x05 offered while full is not accepted; then pop 4 words -> output is 0x01,0x02,0x03,0x04 in that order.
REQ-032 Wrap-around: perform 10 pushes of 0x10..0x19 interleaved with pops, keeping count <= 3 -> output order matches the input order exactly across pointer wrap.
REQ-033 Streaming: in_valid=1 and out_ready=1 every cycle after the first word -> count stays at 1, one word per cycle, with no bubbles and in_ready=1 throughout.
REQ-034 Backpressure: with out_valid=1 and out_data=0x33, hold out_ready=0 for 5 cycles -> out_data remains 0x33 and out_valid remains 1; raise out_ready -> 0x33 is popped once.
REQ-035 Mid-operation reset: with count=3 (0x21..0x23), pulse rst for 1 cycle -> count=0, out_valid=0, in_ready=0 during reset; then push 0x77 -> the first output is 0x77.
